// File: rtl/aoi_2_2_pkg.sv
// Shared constants and types for the AOI-2-2 seven-segment demo.
package aoi_2_2_pkg;

    // Seven-segment cathode patterns, active-low, bit order g f e d c b a.
    localparam logic [6:0] SEG_ONE   = 7'b1111001;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit anode patterns, active-low.
    localparam logic [3:0] AN_DIGIT0 = 4'b1110;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Number of switch inputs handled by the block.
    localparam int NUM_SW = 4;

    // Conditioned switch vector, one field per AOI operand.
    typedef struct packed {
        logic d;
        logic c;
        logic b;
        logic a;
    } sw_vec_t;

endpackage : aoi_2_2_pkg

// File: rtl/aoi_2_2_switch_conditioner.sv
// Single-bit switch conditioner: a SYNC_STAGES-deep synchroniser followed by
// an optional consecutive-cycle debounce filter. Legal SYNC_STAGES is 2..4.
module switch_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    // Shift the raw switch into the synchroniser chain; bit 0 is the first stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Synchroniser flops, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            // Without debounce the last synchroniser stage is the accepted value.
            assign dout = sync_out;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            // Count reaches DEBOUNCE_CYCLES-1 after that many differing samples;
            // the next differing sample is the accepting one.
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic             acc_d;
            logic             acc_q;
            logic [CNT_W-1:0] cnt_d;
            logic [CNT_W-1:0] cnt_q;

            // Count consecutive samples that disagree with the accepted value;
            // any agreeing sample clears the count.
            always_comb begin
                acc_d = acc_q;
                cnt_d = '0;
                if (sync_out != acc_q) begin
                    if (cnt_q == CNT_LAST) begin
                        acc_d = sync_out;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            // Accepted value and counter; reset discards any pending change.
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_d;
                end
            end

            assign dout = acc_q;
        end
    endgenerate

endmodule : switch_conditioner

// File: rtl/aoi_2_2.sv
// AOI-2-2 gate on four conditioned switches, shown as "0"/"1" on digit 0 of
// a seven-segment display. All outputs are registered.
module aoi_2_2
    import aoi_2_2_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SWT,
    output logic [6:0] SEG,
    output logic [3:0] AN
);

    sw_vec_t    sw_clean;
    logic       y;
    logic [6:0] seg_d;
    logic [6:0] seg_q;
    logic [3:0] an_d;
    logic [3:0] an_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            switch_conditioner #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cond (
                .clk  (CLK),
                .rst  (RST),
                .din  (SWT[gi]),
                .dout (sw_clean[gi])
            );
        end
    endgenerate

    // AND-OR-INVERT on the conditioned switches and glyph selection.
    always_comb begin
        y     = ~((sw_clean.a & sw_clean.b) | (sw_clean.c & sw_clean.d));
        seg_d = y ? SEG_ONE : SEG_ZERO;
        an_d  = AN_DIGIT0;
    end

    // Output registers: blank display with all digits off while in reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_q <= SEG_BLANK;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;

endmodule : aoi_2_2

// File: tb/tb_aoi_2_2.sv
// Directed testbench for aoi_2_2: one instance without debounce and one with
// a 4-cycle debounce, driven from the same switches.
module tb_aoi_2_2;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] SWT;
    logic [6:0] seg_a;
    logic [3:0] an_a;
    logic [6:0] seg_b;
    logic [3:0] an_b;

    int checks = 0;
    int errors = 0;

    logic rst_seen = 1'b1;
    logic armed    = 1'b0;

    localparam logic [6:0] ONE   = 7'b1111001;
    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] BLANK = 7'b1111111;

    aoi_2_2 #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut (
        .CLK (CLK), .RST (RST), .SWT (SWT), .SEG (seg_a), .AN (an_a)
    );

    aoi_2_2 #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_db (
        .CLK (CLK), .RST (RST), .SWT (SWT), .SEG (seg_b), .AN (an_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    always @(posedge CLK) rst_seen <= RST;

    // Every cycle: anodes follow reset state, segments only take legal glyphs.
    always @(negedge CLK) begin
        if (armed) begin
            chk("an_a", 32'(an_a), rst_seen ? 32'hF : 32'hE);
            chk("an_b", 32'(an_b), rst_seen ? 32'hF : 32'hE);
            chk("seg_legal_a", 32'(seg_a == ONE || seg_a == ZERO || seg_a == BLANK), 32'd1);
            chk("seg_legal_b", 32'(seg_b == ONE || seg_b == ZERO || seg_b == BLANK), 32'd1);
        end
    end

    initial begin
        logic [15:0] zero_tbl;
        logic [15:0] pat;

        // Reset held 3 cycles with all switches on.
        RST = 1'b1;
        SWT = 4'hF;
        tick(3);
        armed = 1'b1;
        chk("rst_seg_a", 32'(seg_a), 32'(BLANK));
        chk("rst_an_a",  32'(an_a),  32'hF);
        chk("rst_seg_b", 32'(seg_b), 32'(BLANK));
        chk("rst_an_b",  32'(an_b),  32'hF);

        RST = 1'b0;
        tick(1);
        chk("rel1_seg_a", 32'(seg_a), 32'(ONE));
        chk("rel1_seg_b", 32'(seg_b), 32'(ONE));
        tick(1);
        chk("rel2_seg_a", 32'(seg_a), 32'(ONE));
        tick(1);
        chk("rel3_seg_a", 32'(seg_a), 32'(ZERO));
        tick(1);
        chk("rel4_seg_a", 32'(seg_a), 32'(ZERO));
        chk("rel4_seg_b", 32'(seg_b), 32'(ONE));
        tick(2);
        chk("rel6_seg_b", 32'(seg_b), 32'(ONE));
        tick(1);
        chk("rel7_seg_b", 32'(seg_b), 32'(ZERO));

        // Latency: 0000 -> 0011; 3 edges without debounce, 7 with.
        SWT = 4'h0;
        tick(10);
        chk("lat_pre_a", 32'(seg_a), 32'(ONE));
        chk("lat_pre_b", 32'(seg_b), 32'(ONE));
        SWT = 4'h3;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            chk($sformatf("lat_a_e%0d", e), 32'(seg_a), (e >= 3) ? 32'(ZERO) : 32'(ONE));
            chk($sformatf("lat_b_e%0d", e), 32'(seg_b), (e >= 7) ? 32'(ZERO) : 32'(ONE));
        end

        // Simultaneous change 0011 -> 1100: output stays "0" throughout.
        SWT = 4'hC;
        for (int e = 1; e <= 12; e++) begin
            tick(1);
            chk($sformatf("simul_a_e%0d", e), 32'(seg_a), 32'(ZERO));
            chk($sformatf("simul_b_e%0d", e), 32'(seg_b), 32'(ZERO));
        end

        // Short pulse (3 cycles) and a bounce (3 on, 1 off, 3 on) are rejected.
        SWT = 4'h0;
        tick(12);
        chk("deb_pre_b", 32'(seg_b), 32'(ONE));
        pat = 16'b1110_0000_0000_0000;
        for (int i = 15; i >= 0; i--) begin
            SWT = pat[i] ? 4'h3 : 4'h0;
            tick(1);
            chk($sformatf("pulse_b_%0d", 15 - i), 32'(seg_b), 32'(ONE));
        end
        pat = 16'b1110_1110_0000_0000;
        for (int i = 15; i >= 0; i--) begin
            SWT = pat[i] ? 4'h3 : 4'h0;
            tick(1);
            chk($sformatf("bounce_b_%0d", 15 - i), 32'(seg_b), 32'(ONE));
        end

        // Reset mid-debounce: full latency restarts from release.
        SWT = 4'h3;
        tick(4);
        RST = 1'b1;
        tick(1);
        chk("abort_rst_seg_b", 32'(seg_b), 32'(BLANK));
        chk("abort_rst_an_b",  32'(an_b),  32'hF);
        RST = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick(1);
            chk($sformatf("abort_a_e%0d", e), 32'(seg_a), (e >= 3) ? 32'(ZERO) : 32'(ONE));
            chk($sformatf("abort_b_e%0d", e), 32'(seg_b), (e >= 7) ? 32'(ZERO) : 32'(ONE));
        end

        // Exhaustive sweep: bit v set means SWT=v shows "0".
        zero_tbl = 16'hF888;
        for (int v = 0; v < 16; v++) begin
            SWT = 4'(v);
            tick(10);
            chk($sformatf("sweep_a_%0d", v), 32'(seg_a), zero_tbl[v] ? 32'(ZERO) : 32'(ONE));
            chk($sformatf("sweep_b_%0d", v), 32'(seg_b), zero_tbl[v] ? 32'(ZERO) : 32'(ONE));
        end

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_aoi_2_2

// File: doc/aoi_2_2.md
AOI_2_2 -- requirements
Module: aoi_2_2

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of flip-flop stages synchronising each switch input; the legal range is 2 to 4.
REQ-002 Parameter DEBOUNCE_CYCLES, default 0, is the number of consecutive stable clock cycles required before a switch change is accepted; 0 means no debounce.
REQ-003 CLK  input  1  is the single system clock; all state SHALL change only on its rising edge.
REQ-004 RST  input  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 SWT  input  4  carries the switch inputs: SWT[0]=a, SWT[1]=b, SWT[2]=c, SWT[3]=d; they are asynchronous to CLK.
REQ-006 SEG  output  7  drives the seven-segment cathodes, active-low, in bit order SEG[6:0] = g f e d c b a.
REQ-007 AN  output  4  drives the digit anodes, active-low.

Function
REQ-008 The block SHALL compute y = NOT((a AND b) OR (c AND d)) from the synchronised, debounced switch values.
REQ-009 When y = 1, the block SHALL drive SEG = 7'b1111001, showing "1" (segments b and c lit).
REQ-010 When y = 0, the block SHALL drive SEG = 7'b1000000, showing "0" (segments a to f lit, g off).
REQ-011 Outside reset, the block SHALL drive AN = 4'b1110, so that only digit 0 is enabled; AN SHALL never change outside reset.
REQ-012 Each SWT bit SHALL pass through its own SYNC_STAGES-deep flip-flop chain; no combinational path SHALL exist from SWT to SEG.
REQ-013 If DEBOUNCE_CYCLES > 0, each synchronised bit SHALL be accepted only after it has differed from the accepted value on DEBOUNCE_CYCLES consecutive cycles.
REQ-014 If a bit returns to its accepted value before acceptance, its debounce counter SHALL clear; each bit has its own counter, and the counter width is clog2(DEBOUNCE_CYCLES+1).
REQ-015 SEG and AN SHALL be registered outputs.
REQ-016 Latency from an SWT change to the SEG update SHALL be exactly SYNC_STAGES + 1 cycles with no debounce, and SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles with debounce.
REQ-017 Simultaneous changes on several SWT bits SHALL be evaluated as one new input vector with no intermediate glitch value, provided all bits settle in the same cycle.
REQ-018 SEG SHALL only ever take the values 7'b1111001, 7'b1000000 or 7'b1111111.

Reset
REQ-019 While RST = 1 at a rising edge, the block SHALL clear all synchroniser stages, accepted switch values and debounce counters to 0.
REQ-020 While RST = 1 at a rising edge, the block SHALL set SEG = 7'b1111111 (blank) and AN = 4'b1111 (all digits off).
REQ-021 On the first edge after RST falls, SEG SHALL show the value for the cleared inputs (0000, giving "1"), and AN SHALL become 4'b1110.
REQ-022 After reset release, SWT SHALL propagate to SEG with the latency of REQ-016.
REQ-023 Asserting RST during an operation SHALL abort any pending debounce, with no partial state retained.

Structure
REQ-024 A shared package SHALL hold the constants SEG_ONE = 7'b1111001, SEG_ZERO = 7'b1000000, SEG_BLANK = 7'b1111111, AN_DIGIT0 = 4'b1110 and AN_OFF = 4'b1111.
REQ-025 One sub-module, switch_conditioner, SHALL implement the synchroniser plus debounce for a single bit and SHALL be instantiated four times.
REQ-026 The AOI logic and the segment selection SHALL reside in aoi_2_2 itself.

Verification
REQ-027 Exhaustive sweep: apply all 16 SWT values, holding each for at least latency + 2 cycles; SEG SHALL equal 7'b1000000 for 0011, 0111, 1011, 1100, 1101, 1110 and 1111, and 7'b1111001 for all others.
REQ-028 Reset: hold RST = 1 for 3 cycles with SWT = 1111; SEG SHALL be 7'b1111111 and AN 4'b1111; one edge after release, SEG SHALL be 7'b1111001; SYNC_STAGES + 1 edges later, SEG SHALL be 7'b1000000.
REQ-029 Latency, SYNC_STAGES = 2 and DEBOUNCE_CYCLES = 0: step SWT from 0000 to 0011; SEG SHALL change to 7'b1000000 on exactly the third rising edge after the step.
REQ-030 Debounce, DEBOUNCE_CYCLES = 4: pulse SWT[0] and SWT[1] high for 3 cycles from 0000; SEG SHALL stay 7'b1111001; holding them for 6 cycles SHALL produce 7'b1000000.
REQ-031 Simultaneous change: step SWT from 0011 to 1100 in one cycle; SEG SHALL remain 7'b1000000 on every cycle with no transient 7'b1111001.
REQ-032 AN check: AN SHALL read 4'b1110 on every cycle outside reset throughout all scenarios.
